// File: rtl/b2g_stream_if.sv
// Valid/ready stream bundle shared by the binary input and Gray output sides
// of the binary-to-Gray encoder.
interface b2g_stream_if #(
  parameter int unsigned WIDTH = 4
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/b2g_stream.sv
// Streaming binary-to-Gray encoder: words are encoded on write into a small FIFO
// so a stalled consumer never loses data; counts delivered words for debug.
module b2g_stream #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  b2g_stream_if.slave             in_s,
  b2g_stream_if.master            out_m,
  output logic [$clog2(DEPTH):0]  fill,
  output logic [CNT_W-1:0]        sent_cnt
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned FillW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [FillW-1:0] fill_q;
  logic [CNT_W-1:0] sent_cnt_q;
  logic             empty, full, push, pop;

  assign empty = (fill_q == '0);
  assign full  = (fill_q == FillW'(DEPTH));

  // Ready depends only on registered occupancy: no pass-through when full.
  assign in_s.ready  = en & ~full;
  assign out_m.valid = en & ~empty;
  assign out_m.data  = empty ? '0 : mem_q[rd_ptr_q];

  assign push = in_s.valid & in_s.ready;
  assign pop  = out_m.valid & out_m.ready;

  assign fill     = fill_q;
  assign sent_cnt = sent_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      sent_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_s.data ^ (in_s.data >> 1);
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        sent_cnt_q <= sent_cnt_q + CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fill_q <= fill_q + FillW'(1);
        2'b01:   fill_q <= fill_q - FillW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: tb/tb_b2g_stream.sv
// Table-driven bench for b2g_stream: inputs are applied mid-cycle and the
// pre-edge outputs are compared against hand-computed values.
module tb_b2g_stream;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] fill;
  logic [7:0] sent_cnt;

  b2g_stream_if #(.WIDTH(4)) in_if ();
  b2g_stream_if #(.WIDTH(4)) out_if ();

  b2g_stream #(
    .WIDTH (4),
    .DEPTH (2),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_s     (in_if),
    .out_m    (out_if),
    .fill     (fill),
    .sent_cnt (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       iv;
    logic [3:0] bin;
    logic       ordy;
    logic       ird;
    logic       ov;
    logic [3:0] gray;
    logic [1:0] fill;
    logic [7:0] cnt;
  } vec_t;

  vec_t       vq[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] lut [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic add(input logic r, input logic e, input logic iv, input logic [3:0] bin,
                     input logic ordy, input logic ird, input logic ov, input logic [3:0] gray,
                     input logic [1:0] f, input logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.en = e; v.iv = iv; v.bin = bin; v.ordy = ordy;
    v.ird = ird; v.ov = ov; v.gray = gray; v.fill = f; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic e, input logic iv, input logic [3:0] bin,
                       input logic ordy);
    @(negedge clk);
    rst = r; en = e; in_if.valid = iv; in_if.data = bin; out_if.ready = ordy;
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    drive(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("rst_in_ready", 0, 32'(in_if.ready), 32'd1);
    chk("rst_out_valid", 0, 32'(out_if.valid), 32'd0);
    chk("rst_out_gray", 0, 32'(out_if.data), 32'd0);
    chk("rst_fill", 0, 32'(fill), 32'd0);
    chk("rst_sent_cnt", 0, 32'(sent_cnt), 32'd0);

    // Streaming 0,1,2,3,7,8,15 with consumer always ready
    //  rst  en    iv    bin    ordy  ird   ov    gray   fill  cnt
    add(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, 8'd0);
    add(1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 4'h0, 2'd1, 8'd0);
    add(1'b0, 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 4'h1, 2'd1, 8'd1);
    add(1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 4'h3, 2'd1, 8'd2);
    add(1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 4'h2, 2'd1, 8'd3);
    add(1'b0, 1'b1, 1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 4'h4, 2'd1, 8'd4);
    add(1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'hC, 2'd1, 8'd5);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h8, 2'd1, 8'd6);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, 8'd7);

    // Stalled consumer: 5,6 fill the FIFO, 9 is held off until a pop frees space
    add(1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 8'd7);
    add(1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 4'h7, 2'd1, 8'd7);
    add(1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 4'h7, 2'd2, 8'd7);
    add(1'b0, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 4'h7, 2'd2, 8'd7);
    add(1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 4'h5, 2'd1, 8'd8);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h5, 2'd2, 8'd8);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hD, 2'd1, 8'd9);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, 8'd10);

    // Fill=1 with simultaneous push and pop: output lags by one word
    add(1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 8'd10);
    for (int i = 0; i < 10; i++) begin
      add(1'b0, 1'b1, 1'b1, 4'(i), 1'b1, 1'b1, 1'b1, (i == 0) ? lut[10] : lut[i-1],
          2'd1, 8'(10 + i));
    end
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hD, 2'd1, 8'd20);

    // en low for 3 cycles with fill=2: handshakes frozen, contents kept
    add(1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 8'd21);
    add(1'b0, 1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 4'h2, 2'd1, 8'd21);
    for (int i = 0; i < 3; i++) begin
      add(1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 4'h2, 2'd2, 8'd21);
    end
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2, 2'd2, 8'd21);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h6, 2'd1, 8'd22);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, 8'd23);

    // Reset with fill=2 discards both words and overrides a push in the same cycle
    add(1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 8'd23);
    add(1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 4'h1, 2'd1, 8'd23);
    add(1'b1, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 4'h1, 2'd2, 8'd23);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, 8'd0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, 8'd0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].en, vq[i].iv, vq[i].bin, vq[i].ordy);
      chk("in_ready", i, 32'(in_if.ready), 32'(vq[i].ird));
      chk("out_valid", i, 32'(out_if.valid), 32'(vq[i].ov));
      chk("out_gray", i, 32'(out_if.data), 32'(vq[i].gray));
      chk("fill", i, 32'(fill), 32'(vq[i].fill));
      chk("sent_cnt", i, 32'(sent_cnt), 32'(vq[i].cnt));
    end

    // 256 push-then-pop pairs: counter wraps to 0, the next pop gives 1
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'(i), 1'b0);
      drive(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
      if (i % 64 == 63) begin
        chk("wrap_gray", i, 32'(out_if.data), 32'(lut[i % 16]));
        chk("wrap_cnt_pre", i, 32'(sent_cnt), 32'(i));
      end
    end
    drive(1'b0, 1'b1, 1'b1, 4'h6, 1'b0);
    chk("wrap_cnt_zero", 256, 32'(sent_cnt), 32'd0);
    chk("wrap_fill", 256, 32'(fill), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("wrap_gray_257", 257, 32'(out_if.data), 32'h5);
    drive(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("wrap_cnt_one", 257, 32'(sent_cnt), 32'd1);
    chk("wrap_empty", 257, 32'(out_if.valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b2g_stream.md
Name: b2g_stream

Overview:
Streaming binary-to-Gray encoder with valid/ready handshakes on both sides. It is the transmit-side counterpart to the Gray-to-binary decode path. Binary words are accepted, converted (gray = bin ^ (bin >> 1)) and buffered in a small output FIFO so a stalled consumer does not drop data. It also keeps a running count of delivered words for debug.

Parameters:
- WIDTH, 4, data width of binary input and Gray output
- DEPTH, 2, output FIFO entries (power of 2, >= 2)
- CNT_W, 8, width of the delivered-word counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  block enable; 0 freezes both handshakes
- in_valid  input  1  in_bin holds a word
- in_ready  output  1  block can accept a word this cycle
- in_bin  input  WIDTH  binary word
- out_valid  output  1  out_gray holds a word
- out_ready  input  1  consumer takes a word this cycle
- out_gray  output  WIDTH  Gray-coded word at FIFO head
- fill  output  $clog2(DEPTH)+1  current FIFO occupancy
- sent_cnt  output  CNT_W  words delivered since reset, wraps

Behaviour:
- Reset (sampled at the clk edge): fill=0, out_valid=0, out_gray=0, sent_cnt=0, rd/wr pointers=0.
- Reset has priority over everything else. Reset mid-stream discards all buffered words; nothing is emitted for them.
- push = en & in_valid & in_ready
- pop = en & out_valid & out_ready
- in_ready = en & (fill < DEPTH). It is combinational from registered fill and en only, never from out_ready. There is no pass-through when full.
- out_valid = en & (fill != 0)
- out_gray = mem[rd_ptr] whenever fill != 0, else 0.
- Encoding is done at write time: mem[wr_ptr] <= in_bin ^ (in_bin >> 1). The MSB passes through unchanged.
- Latency: a word pushed at edge k is visible at out_gray with out_valid=1 from edge k onward, when the FIFO was empty. Minimum latency is 1 cycle.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- fill update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop (allowed whenever 0 < fill < DEPTH)
- Full (fill == DEPTH): in_ready=0 and in_bin is ignored. A pop in that cycle makes in_ready=1 the next cycle.
- Empty (fill == 0): out_valid=0 and out_ready is ignored. A push into an empty FIFO plus out_ready=1 in the same cycle does not pop.
- sent_cnt increments by 1 on every pop and wraps from 2^CNT_W-1 to 0. It is not cleared by en=0.
- en=0 holds FIFO contents, pointers, fill and sent_cnt. in_ready and out_valid read 0. Operation resumes with the same data when en returns to 1.
- Data ordering is strict FIFO. Output words are never duplicated or reordered.

Test Plan:
- Reset then en=1, push bin 0,1,2,3,7,8,15 with out_ready=1 -> out_gray 0,1,3,2,4,C,8 in order, each 1 cycle after push; sent_cnt=7.
- out_ready=0, push 5,6,9 -> 5 and 6 accepted (gray 7,5); in_ready=0 with fill=2; 9 is held off. Raise out_ready -> 7 pops, in_ready rises next cycle, 9 is accepted and emitted as D.
- fill=1, simultaneous push and pop for 10 cycles with bin 0..9 -> fill stays 1; output stream is the previous word's Gray code each cycle.
- Mid-stream with fill=2, drop en for 3 cycles -> in_ready=0, out_valid=0, fill=2 held; en=1 -> same two words emerge in order.
- Reset asserted with fill=2 -> next cycle fill=0, out_valid=0, sent_cnt=0; the old words never appear.
- 256 pops with CNT_W=8 -> sent_cnt wraps to 0; the 257th pop gives 1.
